// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate response checker:
// FSM encoding, width constants and the coverage-complete helper.
package gate_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int MAX_N_IN  = 4;
   localparam int MAX_COV_W = 1 << MAX_N_IN;
   localparam int SETTLE_W  = 4;

   // True when the low 2**n_in bits of map are all set.
   function automatic logic cover_full(
      input logic [MAX_COV_W-1:0] map,
      input int                   n_in
   );
      logic full;
      full = 1'b1;
      for (int k = 0; k < MAX_COV_W; k++) begin
         if ((k < (1 << n_in)) && !map[k]) full = 1'b0;
      end
      return full;
   endfunction

endpackage

// File: rtl/gate_check_settle_timer.sv
// Settle-time down-counter: load a value, count down,
// pulse expire while the count sits at one.
module gate_check_settle_timer
   import gate_check_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [SETTLE_W-1:0] value,
   output logic                expire
);

   logic [SETTLE_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - SETTLE_W'(1);
      end
   end

   assign expire = (count == SETTLE_W'(1));

endmodule

// File: rtl/gate_response_checker.sv
// Observing end of the gate harness: accepts vectors, waits for
// the gate to settle, scores its output against a truth table.
module gate_response_checker
   import gate_check_pkg::*;
#(
   parameter int                    N_IN          = 2,
   parameter logic [(1<<N_IN)-1:0]  TRUTH_TABLE   = 4'b1000,
   parameter int                    SETTLE_CYCLES = 2,
   parameter int                    ERR_W         = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   input  logic [N_IN-1:0]       dut_in,
   input  logic                  dut_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [(1<<N_IN)-1:0]  cover_map,
   output logic                  first_fail_valid,
   output logic [N_IN-1:0]       first_fail_in
);

   localparam int COV_W = 1 << N_IN;

   state_t              state_q;
   state_t              state_d;
   logic [N_IN-1:0]     cap_q;
   logic [N_IN-1:0]     cap_d;
   logic [ERR_W-1:0]    err_d;
   logic [ERR_W-1:0]    err_inc;
   logic [COV_W-1:0]    cov_d;
   logic [COV_W-1:0]    cov_hit;
   logic                ffv_d;
   logic [N_IN-1:0]     ffi_d;
   logic                pass_d;
   logic                load;
   logic                expire;
   logic                mismatch;

   function automatic logic all_covered(input logic [COV_W-1:0] m);
      logic [MAX_COV_W-1:0] ext;
      ext            = '0;
      ext[COV_W-1:0] = m;
      return cover_full(ext, N_IN);
   endfunction

   gate_check_settle_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .value  (SETTLE_W'(SETTLE_CYCLES)),
      .expire (expire)
   );

   always_comb begin
      state_d  = state_q;
      cap_d    = cap_q;
      err_d    = err_count;
      cov_d    = cover_map;
      ffv_d    = first_fail_valid;
      ffi_d    = first_fail_in;
      pass_d   = pass;
      load     = 1'b0;
      mismatch = (dut_out != TRUTH_TABLE[cap_q]);
      err_inc  = (err_count == '1) ? err_count
                                   : err_count + ERR_W'(1);
      cov_hit  = cover_map;
      cov_hit[cap_q] = 1'b1;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               err_d   = '0;
               cov_d   = '0;
               ffv_d   = 1'b0;
               ffi_d   = '0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = DONE;
               pass_d  = (err_count == '0) && all_covered(cover_map);
            end else if (sample_valid && sample_ready) begin
               cap_d   = dut_in;
               load    = 1'b1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            // stop outranks a compare landing on the same edge
            if (stop) begin
               state_d = DONE;
               pass_d  = (err_count == '0) && all_covered(cover_map);
            end else if (expire) begin
               cov_d = cov_hit;
               if (mismatch) begin
                  err_d = err_inc;
                  if (!first_fail_valid) begin
                     ffv_d = 1'b1;
                     ffi_d = cap_q;
                  end
               end
               if (all_covered(cov_hit)) begin
                  state_d = DONE;
                  pass_d  = (err_d == '0);
               end else begin
                  state_d = RUN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         cap_q            <= '0;
         err_count        <= '0;
         cover_map        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_in    <= '0;
         pass             <= 1'b0;
         done             <= 1'b0;
         busy             <= 1'b0;
         sample_ready     <= 1'b0;
      end else begin
         state_q          <= state_d;
         cap_q            <= cap_d;
         err_count        <= err_d;
         cover_map        <= cov_d;
         first_fail_valid <= ffv_d;
         first_fail_in    <= ffi_d;
         pass             <= pass_d;
         done             <= (state_d == DONE);
         busy             <= (state_d == RUN) || (state_d == SETTLE);
         sample_ready     <= (state_d == RUN);
      end
   end

endmodule
